// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and RVC helpers for the fetch aligner
package fetch_pkg;
  localparam int ILEN = 32;
  localparam logic [1:0] RVC_UNCOMP = 2'b11;
  typedef enum logic [1:0] {ALIGNED, HALF, SKIP} fa_state_e;
  function automatic logic is_rvc(input logic [15:0] h);
    return h[1:0] != RVC_UNCOMP;
  endfunction
endpackage

// File: rtl/fetch_aligner.sv
// fetch_aligner: RV32IC fetch pointer and halfword realigner feeding IF/ID
//   clk, rst                 clock, synchronous active-high reset
//   stall                    IF/ID not loading, current instruction held
//   redirect, redirect_pc    flush and restart fetch at redirect_pc
//   imem_rdata, imem_valid   word read at imem_addr and its valid flag
//   imem_addr, imem_req      word-aligned fetch address and request
//   inst_out, inst_pc        instruction (RVC zero-extended) and its PC
//   inst_compressed          inst_out is a 16-bit encoding
//   inst_valid               inst_* outputs are meaningful this cycle
module fetch_aligner
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [31:0]     imem_addr,
  output logic            imem_req,
  output logic [ILEN-1:0] inst_out,
  output logic [31:0]     inst_pc,
  output logic            inst_compressed,
  output logic            inst_valid
);
  fa_state_e   state_q, state_d;
  logic [31:2] fetch_addr_q, fetch_addr_d, fetch_inc;
  logic [15:0] hold_data_q, hold_data_d;
  logic [31:1] hold_pc_q, hold_pc_d;
  logic        hold_rvc, word_rvc, consume, take_hi, advance;
  logic        rpc_unused;
  assign rpc_unused = redirect_pc[0];
  assign hold_rvc   = is_rvc(hold_data_q);
  assign word_rvc   = is_rvc(imem_rdata[15:0]);
  assign fetch_inc  = fetch_addr_q + 30'd1;
  assign imem_addr  = {fetch_addr_q, 2'b00};
  always_comb begin
    imem_req        = !rst && !(state_q == HALF && hold_rvc);
    inst_valid      = !rst && !redirect &&
                      (state_q == ALIGNED ? imem_valid :
                       state_q == HALF    ? (hold_rvc || imem_valid) : 1'b0);
    inst_compressed = state_q == ALIGNED ? word_rvc : (state_q == HALF && hold_rvc);
    inst_pc         = state_q == HALF ? {hold_pc_q, 1'b0} : imem_addr;
    inst_out        = state_q == HALF    ? (hold_rvc ? {16'h0, hold_data_q} : {imem_rdata[15:0], hold_data_q}) :
                      state_q == ALIGNED ? (word_rvc ? {16'h0, imem_rdata[15:0]} : imem_rdata) : '0;
  end
  // take_hi: the upper halfword of the current word is buffered and the word pointer advances
  always_comb begin
    consume      = inst_valid && !stall;
    take_hi      = state_q == SKIP ? imem_valid :
                   consume && (state_q == ALIGNED ? word_rvc : !hold_rvc);
    advance      = take_hi || (consume && state_q == ALIGNED && !word_rvc);
    state_d      = redirect ? (redirect_pc[1] ? SKIP : ALIGNED) :
                   take_hi  ? HALF :
                   consume  ? ALIGNED : state_q;
    fetch_addr_d = redirect ? redirect_pc[31:2] : advance ? fetch_inc : fetch_addr_q;
    hold_data_d  = redirect ? 16'h0 : take_hi ? imem_rdata[31:16] : hold_data_q;
    hold_pc_d    = redirect ? 31'h0 : take_hi ? {fetch_addr_q, 1'b1} : hold_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RESET_PC[1] ? SKIP : ALIGNED;
      fetch_addr_q <= RESET_PC[31:2];
      hold_data_q  <= 16'h0;
      hold_pc_q    <= 31'h0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      hold_data_q  <= hold_data_d;
      hold_pc_q    <= hold_pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: directed vectors plus a halfword-stream reference model
module tb_fetch_aligner;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic        clk, rst, stall, redirect, imem_valid, imem_req, inst_compressed, inst_valid;
  logic [31:0] redirect_pc, imem_rdata, imem_addr, inst_out, inst_pc;
  logic [31:0] mem [0:255];
  logic [31:0] mpc;
  int n_chk = 0, n_fail = 0;

  fetch_aligner #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_req(imem_req),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_compressed(inst_compressed), .inst_valid(inst_valid)
  );

  assign imem_rdata = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [15:0] half(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[9:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: the program is a halfword stream; each valid output must be the
  // instruction starting at mpc, and a consume steps mpc by its length.
  always @(negedge clk) begin
    logic [15:0] h;
    logic        c;
    logic [31:0] e;
    chk("addr_aligned", {30'h0, imem_addr[1:0]}, 32'h0);
    if (rst) begin
      chk("rst_valid", inst_valid, 0);
      chk("rst_req", imem_req, 0);
      mpc = RESET_PC;
    end else if (redirect) begin
      chk("redir_valid", inst_valid, 0);
      mpc = redirect_pc & ~32'h1;
    end else if (inst_valid) begin
      h = half(mpc);
      c = h[1:0] != 2'b11;
      e = c ? {16'h0, h} : {half(mpc + 32'd2), h};
      chk("model_pc", inst_pc, mpc);
      chk("model_inst", inst_out, e);
      chk("model_comp", inst_compressed, c);
      if (!stall) mpc = mpc + (c ? 32'd2 : 32'd4);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic ckv(input string nm, input logic [31:0] o, input logic [31:0] p, input logic c,
                     input logic r, input logic [31:0] a);
    @(negedge clk);
    chk({nm, ".valid"}, inst_valid, 1);
    chk({nm, ".inst"}, inst_out, o);
    chk({nm, ".pc"}, inst_pc, p);
    chk({nm, ".comp"}, inst_compressed, c);
    chk({nm, ".req"}, imem_req, r);
    chk({nm, ".addr"}, imem_addr, a);
    adv();
  endtask

  task automatic cki(input string nm, input logic r, input logic [31:0] a);
    @(negedge clk);
    chk({nm, ".valid"}, inst_valid, 0);
    chk({nm, ".req"}, imem_req, r);
    chk({nm, ".addr"}, imem_addr, a);
    adv();
  endtask

  task automatic rst_on();
    rst = 1; redirect = 0; stall = 0; imem_valid = 1; redirect_pc = 0;
  endtask

  task automatic rst_off();
    @(negedge clk);
    chk("reset.valid", inst_valid, 0);
    chk("reset.req", imem_req, 0);
    adv();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    mem[64] = 32'h4585_0001; mem[128] = 32'h0093_4501; mem[129] = 32'h1234_0050;
    mem[192] = 32'h0000_0000; mem[255] = 32'h0093_0001;
    rst_on();
    mem[0] = 32'h0050_0093;
    rst_off();
    ckv("t1_c0", 32'h0050_0093, 32'h0, 0, 1, 32'h0);
    ckv("t1_c1", 32'h0000_0013, 32'h4, 0, 1, 32'h4);
    rst_on();
    mem[0] = 32'h4505_4501;
    rst_off();
    ckv("t2_c0", 32'h4501, 32'h0, 1, 1, 32'h0);
    imem_valid = 0;
    ckv("t2_c1", 32'h4505, 32'h2, 1, 0, 32'h4);
    imem_valid = 1;
    ckv("t2_c2", 32'h0000_0013, 32'h4, 0, 1, 32'h4);
    rst_on();
    mem[0] = 32'h0093_4501; mem[1] = 32'h1234_0050; mem[2] = 32'h0000_0013;
    rst_off();
    ckv("t3_c0", 32'h4501, 32'h0, 1, 1, 32'h0);
    ckv("t3_c1", 32'h0050_0093, 32'h2, 0, 1, 32'h4);
    ckv("t3_c2", 32'h1234, 32'h6, 1, 0, 32'h8);
    ckv("t3_c3", 32'h0000_0013, 32'h8, 0, 1, 32'h8);
    stall = 1; redirect = 1; redirect_pc = 32'h102;
    cki("t4_redir", 1, 32'hC);
    redirect = 0;
    cki("t4_skip", 1, 32'h100);
    stall = 0;
    ckv("t4_half", 32'h4585, 32'h102, 1, 0, 32'h104);
    ckv("t4_next", 32'h0000_0013, 32'h104, 0, 1, 32'h104);
    redirect = 1; redirect_pc = 32'h200;
    cki("t5_redir", 1, 32'h108);
    redirect = 0;
    ckv("t5_c0", 32'h4501, 32'h200, 1, 1, 32'h200);
    stall = 1;
    for (int i = 0; i < 3; i++) ckv("t5_stall", 32'h0050_0093, 32'h202, 0, 1, 32'h204);
    stall = 0;
    ckv("t5_rel", 32'h0050_0093, 32'h202, 0, 1, 32'h204);
    ckv("t5_c2", 32'h1234, 32'h206, 1, 0, 32'h208);
    imem_valid = 0;
    cki("t6_a", 1, 32'h208);
    cki("t6_b", 1, 32'h208);
    imem_valid = 1;
    ckv("t6_c", 32'h0000_0013, 32'h208, 0, 1, 32'h208);
    redirect = 1; redirect_pc = 32'h200;
    cki("t7_redir", 1, 32'h20C);
    redirect = 0;
    ckv("t7_c0", 32'h4501, 32'h200, 1, 1, 32'h200);
    rst = 1;
    cki("t7_rst", 0, 32'h204);
    rst = 0;
    ckv("t7_after", 32'h4501, 32'h0, 1, 1, 32'h0);
    ckv("t7_c1", 32'h0050_0093, 32'h2, 0, 1, 32'h4);
    redirect = 1; redirect_pc = 32'hFFFF_FFFE;
    cki("t8_redir", 0, 32'h8);
    redirect = 0;
    cki("t8_skip", 1, 32'hFFFF_FFFC);
    ckv("t8_wrap", 32'h4501_0093, 32'hFFFF_FFFE, 0, 1, 32'h0);
    ckv("t8_after", 32'h0050_0093, 32'h2, 0, 1, 32'h4);
    redirect = 1; redirect_pc = 32'h301;
    cki("t9_redir", 0, 32'h8);
    redirect = 0;
    ckv("t9_c0", 32'h0, 32'h300, 1, 1, 32'h300);
    ckv("t9_c1", 32'h0, 32'h302, 1, 0, 32'h304);
    ckv("t9_c2", 32'h0000_0013, 32'h304, 0, 1, 32'h304);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
